uart_rx_os: RTL and testbench

- Next-generation UART receiver with a parametrised frame format: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits.
- Samples the line at an oversampled rate, with a double-flop synchroniser and 3-sample majority vote.
- Flags parity, framing and break conditions per word.
- Buffers received words in a small first-word-fall-through FIFO behind a valid/ready handshake, so downstream logic can stall without losing characters.

---
 rtl/uart_rx_os.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// uart_rx_os: oversampling UART receiver with configurable frame format,
// 3-sample majority vote, parity/framing/break flags and a FWFT output FIFO.
module uart_rx_os #(
    parameter int unsigned CLK_HZ        = 100000000,
    parameter int unsigned BIT_RATE      = 9600,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned CLKS_PER_TICK = CLK_HZ / (BIT_RATE * OVERSAMPLE),
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_break,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_TICK);
    localparam int unsigned S_W    = $clog2(OVERSAMPLE);
    localparam int unsigned MID    = OVERSAMPLE / 2;
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_LINE_WAIT,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BREAK_WAIT
    } state_t;

    typedef struct packed {
        logic                 brk;
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    logic                 sync1;
    logic                 rxd_s;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 tick_c;

    state_t               state;
    logic [S_W-1:0]       s_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 pbit;
    logic                 v0;
    logic                 v1;
    logic                 ferr;
    logic                 stop_one;
    logic                 push_q;
    entry_t               push_entry;

    logic                 vote_c;
    logic                 at_vote_c;
    logic                 bit_end_c;
    logic                 last_stop_c;
    logic                 brk_c;
    logic                 pe_c;
    entry_t               entry_c;

    entry_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full_c;
    logic                 pop_c;
    logic                 do_push_c;
    entry_t               head_c;

    // Two-flop synchroniser for the asynchronous line, idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxd_s <= sync1;
        end
    end

    assign tick_c = (tick_cnt == TICK_W'(CLKS_PER_TICK - 1));

    // Free-running sample tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    assign vote_c      = (v0 & v1) | (v0 & rxd_s) | (v1 & rxd_s);
    assign at_vote_c   = (s_cnt == S_W'(MID + 1));
    assign bit_end_c   = (s_cnt == S_W'(OVERSAMPLE - 1));
    assign last_stop_c = (stop_idx == 1'(STOP_BITS - 1));

    // Word flags as they stand at the final stop-bit vote.
    always_comb begin
        brk_c = (shift == '0) && ((PARITY == 0) || !pbit) && !stop_one && !vote_c;
        pe_c  = (PARITY != 0) && ((^shift ^ pbit) != (PARITY == 2));
        entry_c            = '0;
        entry_c.brk        = brk_c;
        entry_c.frame_err  = ferr | ~vote_c;
        entry_c.parity_err = pe_c & ~brk_c;
        entry_c.data       = brk_c ? '0 : shift;
    end

    // Receiver FSM, advancing only on sample ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_LINE_WAIT;
            s_cnt      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            pbit       <= 1'b0;
            v0         <= 1'b1;
            v1         <= 1'b1;
            ferr       <= 1'b0;
            stop_one   <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            push_q <= 1'b0;
            if (tick_c) begin
                if (s_cnt == S_W'(MID - 1)) v0 <= rxd_s;
                if (s_cnt == S_W'(MID))     v1 <= rxd_s;
                if (state inside {ST_START, ST_DATA, ST_PAR, ST_STOP}) begin
                    s_cnt <= bit_end_c ? '0 : s_cnt + S_W'(1);
                end
                case (state)
                    ST_LINE_WAIT: begin
                        if (rxd_s) state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (!rxd_s) begin
                            state <= ST_START;
                            s_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (at_vote_c && vote_c) begin
                            state <= ST_IDLE;
                        end else if (bit_end_c) begin
                            state    <= ST_DATA;
                            bit_idx  <= '0;
                            pbit     <= 1'b0;
                            ferr     <= 1'b0;
                            stop_one <= 1'b0;
                            stop_idx <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (at_vote_c) shift[bit_idx] <= vote_c;
                        if (bit_end_c) begin
                            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                                state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end
                    end
                    ST_PAR: begin
                        if (at_vote_c) pbit <= vote_c;
                        if (bit_end_c) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (at_vote_c) begin
                            if (last_stop_c) begin
                                push_q     <= 1'b1;
                                push_entry <= entry_c;
                                s_cnt      <= '0;
                                state      <= brk_c ? ST_BREAK_WAIT : ST_IDLE;
                            end else begin
                                ferr     <= ferr | ~vote_c;
                                stop_one <= stop_one | vote_c;
                            end
                        end else if (bit_end_c) begin
                            stop_idx <= 1'b1;
                        end
                    end
                    ST_BREAK_WAIT: begin
                        if (rxd_s) state <= ST_IDLE;
                    end
                    default: state <= ST_LINE_WAIT;
                endcase
            end
        end
    end

    assign rx_busy = !((state == ST_IDLE) || (state == ST_LINE_WAIT));

    assign m_valid    = (count != '0);
    assign full_c     = (count == CNT_W'(FIFO_DEPTH));
    assign pop_c      = m_valid & m_ready;
    assign do_push_c  = push_q & (~full_c | pop_c);
    assign rx_overrun = push_q & full_c & ~pop_c;

    // FIFO storage; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (!do_push_c && pop_c) count <= count - CNT_W'(1);
        end
    end

    // Head-of-FIFO outputs, forced to zero while empty.
    always_comb begin
        head_c       = mem[rd_ptr];
        m_data       = '0;
        m_parity_err = 1'b0;
        m_frame_err  = 1'b0;
        m_break      = 1'b0;
        if (m_valid) begin
            m_data       = head_c.data;
            m_parity_err = head_c.parity_err;
            m_frame_err  = head_c.frame_err;
            m_break      = head_c.brk;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// tb_uart_rx_os: directed scenarios for the oversampling UART receiver.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic rxd = 1'b1, rxd_e = 1'b1, rxd_o = 1'b1;
    logic ready = 1'b1;
    logic ready_eo = 1'b1;

    logic       v, pe, fe, brk, ovr, busy;
    logic [7:0] d;
    logic       v_e, pe_e, fe_e, brk_e, ovr_e, busy_e;
    logic [7:0] d_e;
    logic       v_o, pe_o, fe_o, brk_o, ovr_o, busy_o;
    logic [6:0] d_o;

    uart_rx_os #(.CLKS_PER_TICK(10)) dut (
        .clk(clk), .reset(reset), .uart_rxd(rxd),
        .m_valid(v), .m_ready(ready), .m_data(d),
        .m_parity_err(pe), .m_frame_err(fe), .m_break(brk),
        .rx_overrun(ovr), .rx_busy(busy)
    );

    uart_rx_os #(.CLKS_PER_TICK(10), .PARITY(1)) dut_e (
        .clk(clk), .reset(reset), .uart_rxd(rxd_e),
        .m_valid(v_e), .m_ready(ready_eo), .m_data(d_e),
        .m_parity_err(pe_e), .m_frame_err(fe_e), .m_break(brk_e),
        .rx_overrun(ovr_e), .rx_busy(busy_e)
    );

    uart_rx_os #(.CLKS_PER_TICK(10), .PARITY(2), .DATA_BITS(7)) dut_o (
        .clk(clk), .reset(reset), .uart_rxd(rxd_o),
        .m_valid(v_o), .m_ready(ready_eo), .m_data(d_o),
        .m_parity_err(pe_o), .m_frame_err(fe_o), .m_break(brk_o),
        .rx_overrun(ovr_o), .rx_busy(busy_o)
    );

    // Accepted words packed as {break, frame_err, parity_err, data[8:0]}.
    logic [11:0] q[$];
    logic [11:0] q_e[$];
    logic [11:0] q_o[$];
    int valid_cycles = 0;
    int ovr_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Record every handshake and event pulse.
    always @(negedge clk) begin
        if (v && ready) q.push_back({brk, fe, pe, 1'b0, d});
        if (v_e && ready_eo) q_e.push_back({brk_e, fe_e, pe_e, 1'b0, d_e});
        if (v_o && ready_eo) q_o.push_back({brk_o, fe_o, pe_o, 2'b00, d_o});
        if (v) valid_cycles++;
        if (ovr) ovr_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int which, input logic val);
        case (which)
            0:       rxd = val;
            1:       rxd_e = val;
            default: rxd_o = val;
        endcase
    endtask

    task automatic hold(input int which, input logic val, input int n);
        drive(which, val);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int which, input logic [8:0] data, input int nbits,
                        input int par_en, input logic pbit, input logic stopv);
        hold(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) hold(which, data[i], BIT_CLKS);
        if (par_en != 0) hold(which, pbit, BIT_CLKS);
        hold(which, stopv, BIT_CLKS);
        drive(which, 1'b1);
    endtask

    task automatic set_ready(input logic val);
        @(posedge clk);
        #1 ready = val;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(5);
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", v); end
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", d); end
        n_checks++; if ({brk, fe, pe} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {brk, fe, pe}); end
        n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ovr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        idle(30);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", v); end
    endtask

    task automatic test_8n1();
        int n0;
        int vc0;
        int n1;
        n0 = q.size();
        vc0 = valid_cycles;
        send(0, 9'h0A5, 8, 0, 1'b0, 1'b1);
        idle(100);
        n_checks++; if (q.size() !== n0 + 1) begin n_fail++; $display("FAIL a5_count: got %0d want %0d", q.size(), n0 + 1); end
        n_checks++; if (q[n0] !== 12'h0A5) begin n_fail++; $display("FAIL a5_word: got %h want 0a5", q[n0]); end
        n_checks++; if (valid_cycles - vc0 !== 1) begin n_fail++; $display("FAIL a5_valid_len: got %0d want 1", valid_cycles - vc0); end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL a5_valid_after: got %b want 0", v); end
        n1 = q.size();
        send(0, 9'h000, 8, 0, 1'b0, 1'b1);
        send(0, 9'h0FF, 8, 0, 1'b0, 1'b1);
        idle(100);
        n_checks++; if (q.size() !== n1 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", q.size(), n1 + 2); end
        n_checks++; if (q[n1] !== 12'h000) begin n_fail++; $display("FAIL b2b_00: got %h want 000", q[n1]); end
        n_checks++; if (q[n1 + 1] !== 12'h0FF) begin n_fail++; $display("FAIL b2b_ff: got %h want 0ff", q[n1 + 1]); end
    endtask

    task automatic test_parity();
        int n0;
        n0 = q_e.size();
        send(1, 9'h003, 8, 1, 1'b0, 1'b1);
        send(1, 9'h003, 8, 1, 1'b1, 1'b1);
        idle(100);
        n_checks++; if (q_e.size() !== n0 + 2) begin n_fail++; $display("FAIL even_count: got %0d want %0d", q_e.size(), n0 + 2); end
        n_checks++; if (q_e[n0] !== 12'h003) begin n_fail++; $display("FAIL even_ok: got %h want 003", q_e[n0]); end
        n_checks++; if (q_e[n0 + 1] !== 12'h203) begin n_fail++; $display("FAIL even_err: got %h want 203", q_e[n0 + 1]); end
        n0 = q_o.size();
        send(2, 9'h041, 7, 1, 1'b1, 1'b1);
        send(2, 9'h041, 7, 1, 1'b0, 1'b1);
        idle(100);
        n_checks++; if (q_o.size() !== n0 + 2) begin n_fail++; $display("FAIL odd_count: got %0d want %0d", q_o.size(), n0 + 2); end
        n_checks++; if (q_o[n0] !== 12'h041) begin n_fail++; $display("FAIL odd_ok: got %h want 041", q_o[n0]); end
        n_checks++; if (q_o[n0 + 1] !== 12'h241) begin n_fail++; $display("FAIL odd_err: got %h want 241", q_o[n0 + 1]); end
    endtask

    task automatic test_framing();
        int n0;
        n0 = q.size();
        send(0, 9'h055, 8, 0, 1'b0, 1'b0);
        idle(400);
        n_checks++; if (q.size() !== n0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d want %0d", q.size(), n0 + 1); end
        n_checks++; if (q[n0] !== 12'h455) begin n_fail++; $display("FAIL ferr_word: got %h want 455", q[n0]); end
        n0 = q.size();
        hold(0, 1'b0, 12 * BIT_CLKS);
        drive(0, 1'b1);
        idle(400);
        n_checks++; if (q.size() !== n0 + 1) begin n_fail++; $display("FAIL break_count: got %0d want %0d", q.size(), n0 + 1); end
        n_checks++; if (q[n0] !== 12'hC00) begin n_fail++; $display("FAIL break_word: got %h want c00", q[n0]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b want 0", busy); end
        n0 = q.size();
        send(0, 9'h03C, 8, 0, 1'b0, 1'b1);
        idle(100);
        n_checks++; if (q.size() !== n0 + 1) begin n_fail++; $display("FAIL after_break_count: got %0d want %0d", q.size(), n0 + 1); end
        n_checks++; if (q[n0] !== 12'h03C) begin n_fail++; $display("FAIL after_break_word: got %h want 03c", q[n0]); end
    endtask

    task automatic test_glitch();
        int n0;
        logic busy_seen;
        n0 = q.size();
        busy_seen = 1'b0;
        drive(0, 1'b0);
        repeat (50) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
        drive(0, 1'b1);
        repeat (300) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
        n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        n_checks++; if (q.size() !== n0) begin n_fail++; $display("FAIL glitch_count: got %0d want %0d", q.size(), n0); end
        n0 = q.size();
        hold(0, 1'b0, 3 * BIT_CLKS);
        hold(0, 1'b0, 75);
        hold(0, 1'b1, 10);
        hold(0, 1'b0, 75);
        hold(0, 1'b0, 5 * BIT_CLKS);
        hold(0, 1'b1, BIT_CLKS);
        idle(100);
        n_checks++; if (q.size() !== n0 + 1) begin n_fail++; $display("FAIL spike_count: got %0d want %0d", q.size(), n0 + 1); end
        n_checks++; if (q[n0] !== 12'h000) begin n_fail++; $display("FAIL spike_word: got %h want 000", q[n0]); end
    endtask

    task automatic test_overrun();
        int n0;
        int o0;
        logic [11:0] exp;
        set_ready(1'b0);
        n0 = q.size();
        o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) send(0, 9'(8'h11 + i), 8, 0, 1'b0, 1'b1);
        idle(50);
        n_checks++; if (ovr_cnt !== o0) begin n_fail++; $display("FAIL ovr_early: got %0d want %0d", ovr_cnt, o0); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", v); end
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL ovr_head_before: got %h want 11", d); end
        send(0, 9'h015, 8, 0, 1'b0, 1'b1);
        idle(50);
        n_checks++; if (ovr_cnt !== o0 + 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d want %0d", ovr_cnt, o0 + 1); end
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL ovr_head_after: got %h want 11", d); end
        set_ready(1'b1);
        idle(20);
        n_checks++; if (q.size() !== n0 + 4) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", q.size(), n0 + 4); end
        for (int i = 0; i < 4; i++) begin
            exp = 12'(8'h11 + i);
            n_checks++; if (q[n0 + i] !== exp) begin n_fail++; $display("FAIL drain_word%0d: got %h want %h", i, q[n0 + i], exp); end
        end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", v); end
    endtask

    task automatic test_reset_midframe();
        int n0;
        n0 = q.size();
        hold(0, 1'b0, BIT_CLKS);
        hold(0, 1'b1, 2 * BIT_CLKS);
        hold(0, 1'b0, 2 * BIT_CLKS);
        hold(0, 1'b0, 80);
        reset = 1'b1;
        idle(4);
        reset = 1'b0;
        idle(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", v); end
        hold(0, 1'b0, 75 + BIT_CLKS);
        hold(0, 1'b1, 3 * BIT_CLKS);
        idle(200);
        n_checks++; if (q.size() !== n0) begin n_fail++; $display("FAIL midreset_count: got %0d want %0d", q.size(), n0); end
        send(0, 9'h07E, 8, 0, 1'b0, 1'b1);
        idle(100);
        n_checks++; if (q.size() !== n0 + 1) begin n_fail++; $display("FAIL post_midreset_count: got %0d want %0d", q.size(), n0 + 1); end
        n_checks++; if (q[n0] !== 12'h07E) begin n_fail++; $display("FAIL post_midreset_word: got %h want 07e", q[n0]); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
